// File: rtl/fxp_booth_mul_seq.sv
// Sequential signed fixed-point multiplier, radix-4 Booth, one partial product per clock.
// Define FXP_MUL_SAT_EN to clamp overflowing results and report them on out_ovf.
module fxp_booth_mul_seq #(
    parameter int WIDTH = 16,
    parameter int FRAC  = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_ovf
);
    localparam int AW  = 2 * WIDTH + 2;
    localparam int NPP = WIDTH / 2;
    localparam int CW  = $clog2(NPP + 1);

    localparam logic signed [AW-1:0] RND =
        {{(AW-1){1'b0}}, 1'b1} << (FRAC - 1);
`ifdef FXP_MUL_SAT_EN
    localparam logic signed [AW-1:0] MAXV =
        {{(AW-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
    localparam logic signed [AW-1:0] MINV =
        {{(AW-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};
`endif

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t                 state;
    logic [WIDTH-1:0]       a_q;
    logic [WIDTH:0]         b_q;
    logic signed [AW-1:0]   acc;
    logic [CW-1:0]          cnt;

    logic signed [AW-1:0]   a_ext;
    logic signed [AW-1:0]   pp;
    logic signed [AW-1:0]   pp_sh;
    logic signed [AW-1:0]   rsum;
    logic signed [AW-1:0]   rq;
    logic [WIDTH-1:0]       res_c;
    logic                   ovf_c;

    // Booth digit from the low three bits of the shifting multiplier window
    always_comb begin
        a_ext = {{(AW-WIDTH){a_q[WIDTH-1]}}, a_q};
        pp    = '0;
        case (b_q[2:0])
            3'b001, 3'b010: pp = a_ext;
            3'b011:         pp = a_ext <<< 1;
            3'b100:         pp = -(a_ext <<< 1);
            3'b101, 3'b110: pp = -a_ext;
            default:        pp = '0;
        endcase
        pp_sh = pp <<< {cnt, 1'b0};
    end

    // Round half toward +inf, rescale, then wrap or clamp
    always_comb begin
        rsum = acc + RND;
        rq   = rsum >>> FRAC;
`ifdef FXP_MUL_SAT_EN
        ovf_c = (rq > MAXV) || (rq < MINV);
        if (rq > MAXV)
            res_c = {1'b0, {(WIDTH-1){1'b1}}};
        else if (rq < MINV)
            res_c = {1'b1, {(WIDTH-1){1'b0}}};
        else
            res_c = rq[WIDTH-1:0];
`else
        ovf_c = 1'b0;
        res_c = rq[WIDTH-1:0];
`endif
    end

    // Control FSM with registered handshake and result outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            in_ready   <= 1'b1;
            out_valid  <= 1'b0;
            out_result <= '0;
            out_ovf    <= 1'b0;
            a_q        <= '0;
            b_q        <= '0;
            acc        <= '0;
            cnt        <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        a_q      <= in_a;
                        b_q      <= {in_b, 1'b0};
                        acc      <= '0;
                        cnt      <= '0;
                        in_ready <= 1'b0;
                        state    <= BUSY;
                    end
                end
                BUSY: begin
                    if (cnt == CW'(NPP)) begin
                        out_result <= res_c;
                        out_ovf    <= ovf_c;
                        out_valid  <= 1'b1;
                        state      <= DONE;
                    end else begin
                        acc <= acc + pp_sh;
                        b_q <= b_q >> 2;
                        cnt <= cnt + CW'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
